// File: rtl/vfd_ramp_ctrl.sv
// Soft-start/soft-stop sequencer: ramps the VFD frequency word at ms-paced rates, latches estop faults.
// Latency: all outputs registered, one clk_sys after the qualifying input; no backpressure (level inputs).
module vfd_ramp_ctrl #(
  parameter int FW      = 10,
  parameter int ACC_MS  = 4,
  parameter int DEC_MS  = 8,
  parameter int F_START = 5,
  parameter int F_MAX   = 1000
) (
  input  logic          clk_sys,
  input  logic          rst,
  input  logic          pluse_ms,
  input  logic          run_req,
  input  logic          estop,
  input  logic [FW-1:0] freq_tgt,
  output logic [FW-1:0] freq_out,
  output logic          drv_en,
  output logic          at_speed,
  output logic          fault,
  output logic [2:0]    state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ACCEL = 3'd1,
    S_RUN   = 3'd2,
    S_DECEL = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  localparam logic [FW-1:0] FSTART_W = FW'(F_START);
  localparam logic [FW-1:0] FMAX_W   = FW'(F_MAX);
  localparam logic [FW-1:0] FONE     = FW'(1);
  localparam logic [7:0]    ACC_LIM  = 8'(ACC_MS - 1);
  localparam logic [7:0]    DEC_LIM  = 8'(DEC_MS - 1);

  state_t        st_q, st_d;
  logic [FW-1:0] freq_q, freq_d;
  logic          drv_q, drv_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [FW-1:0] tgt_c, tgt_e;
  logic          step_due;

  // A target below F_START cannot be held with the drive enabled, so it reads as "stop".
  assign tgt_c = (freq_tgt > FMAX_W) ? FMAX_W : freq_tgt;
  assign tgt_e = (run_req && (tgt_c >= FSTART_W)) ? tgt_c : '0;

  always_comb begin
    step_due = 1'b0;
    if (pluse_ms) begin
      case (st_q)
        S_ACCEL: step_due = (cnt_q == ACC_LIM);
        S_DECEL: step_due = (cnt_q == DEC_LIM);
        default: step_due = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      st_q     <= S_IDLE;
      freq_q   <= '0;
      drv_q    <= 1'b0;
      cnt_q    <= '0;
      at_speed <= 1'b0;
      fault    <= 1'b0;
    end else begin
      st_q     <= st_d;
      freq_q   <= freq_d;
      drv_q    <= drv_d;
      cnt_q    <= cnt_d;
      at_speed <= (st_d == S_RUN);
      fault    <= (st_d == S_FAULT);
    end
  end

  always_comb begin
    st_d = st_q;
    if (estop) begin
      st_d = S_FAULT;
    end else begin
      case (st_q)
        S_IDLE:  if (tgt_e != '0) st_d = S_ACCEL;
        S_ACCEL: begin
          if (freq_q == tgt_e)     st_d = S_RUN;
          else if (tgt_e < freq_q) st_d = S_DECEL;
        end
        S_RUN: begin
          if (tgt_e > freq_q)      st_d = S_ACCEL;
          else if (tgt_e < freq_q) st_d = S_DECEL;
        end
        S_DECEL: begin
          if ((tgt_e != '0) && (freq_q == tgt_e)) st_d = S_RUN;
          else if (tgt_e > freq_q)                st_d = S_ACCEL;
          else if (step_due && (freq_q <= FSTART_W) && (tgt_e == '0)) st_d = S_IDLE;
        end
        S_FAULT: if (!run_req) st_d = S_IDLE;
        default: st_d = S_IDLE;
      endcase
    end
  end

  // A state change swallows any coincident step and restarts the ms prescaler.
  always_comb begin
    freq_d = freq_q;
    drv_d  = drv_q;
    cnt_d  = cnt_q;
    if (st_d != st_q) begin
      cnt_d = '0;
      case (st_d)
        S_IDLE, S_FAULT: begin
          freq_d = '0;
          drv_d  = 1'b0;
        end
        S_ACCEL: begin
          if (st_q == S_IDLE) begin
            freq_d = FSTART_W;
            drv_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end else if ((st_q == S_ACCEL) || (st_q == S_DECEL)) begin
      if (step_due) begin
        cnt_d  = '0;
        freq_d = (st_q == S_ACCEL) ? (freq_q + FONE) : (freq_q - FONE);
      end else if (pluse_ms) begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  assign freq_out = freq_q;
  assign drv_en   = drv_q;
  assign state    = st_q;

endmodule

// File: tb/tb_vfd_ramp_ctrl.sv
// Bench for vfd_ramp_ctrl: table of {inputs, pulse/tick counts, expected outputs} run through a scoreboard queue,
// plus hand-written reset sequences.
module tb_vfd_ramp_ctrl;

  localparam int FW = 10;

  logic          clk_sys;
  logic          rst;
  logic          pluse_ms;
  logic          run_req;
  logic          estop;
  logic [FW-1:0] freq_tgt;
  logic [FW-1:0] freq_out;
  logic          drv_en;
  logic          at_speed;
  logic          fault;
  logic [2:0]    state;

  vfd_ramp_ctrl dut (
    .clk_sys  (clk_sys),
    .rst      (rst),
    .pluse_ms (pluse_ms),
    .run_req  (run_req),
    .estop    (estop),
    .freq_tgt (freq_tgt),
    .freq_out (freq_out),
    .drv_en   (drv_en),
    .at_speed (at_speed),
    .fault    (fault),
    .state    (state)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  typedef struct {
    string         name;
    logic [FW-1:0] freq;
    logic          drv;
    logic          at;
    logic          flt;
    logic [2:0]    st;
  } exp_t;

  typedef struct {
    logic          run;
    logic          es;
    logic [FW-1:0] tgt;
    int            np;
    int            nt;
    exp_t          e;
  } vec_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic add(input string nm, input logic r, input logic es, input int tgt,
                     input int np, input int nt, input int f, input logic d,
                     input logic a, input logic fl, input int st);
    vec_t v;
    v.run    = r;
    v.es     = es;
    v.tgt    = FW'(tgt);
    v.np     = np;
    v.nt     = nt;
    v.e.name = nm;
    v.e.freq = FW'(f);
    v.e.drv  = d;
    v.e.at   = a;
    v.e.flt  = fl;
    v.e.st   = 3'(st);
    vecs.push_back(v);
  endtask

  task automatic push_exp(input string nm, input int f, input logic d, input logic a,
                          input logic fl, input int st);
    exp_t e;
    e.name = nm;
    e.freq = FW'(f);
    e.drv  = d;
    e.at   = a;
    e.flt  = fl;
    e.st   = 3'(st);
    exp_q.push_back(e);
  endtask

  task automatic check_pop();
    exp_t e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: DUT output with no expected record");
    end else begin
      e = exp_q.pop_front();
      if (freq_out !== e.freq || drv_en !== e.drv || at_speed !== e.at ||
          fault !== e.flt || state !== e.st) begin
        n_fail++;
        $display("FAIL %s: got freq=%0d drv=%0b at=%0b flt=%0b st=%0d, want freq=%0d drv=%0b at=%0b flt=%0b st=%0d",
                 e.name, freq_out, drv_en, at_speed, fault, state,
                 e.freq, e.drv, e.at, e.flt, e.st);
      end
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick(input logic p);
    pluse_ms = p;
    @(posedge clk_sys);
    #1;
    pluse_ms = 1'b0;
  endtask

  task automatic pulses(input int n);
    for (int k = 0; k < n; k++) begin
      tick(1'b1);
      tick(1'b0);
    end
  endtask

  initial begin
    rst      = 1'b1;
    pluse_ms = 1'b0;
    run_req  = 1'b0;
    estop    = 1'b0;
    freq_tgt = '0;

    //   name          run es tgt   np    nt  freq drv at flt st
    add("start",        1, 0, 20,    0,   1,    5, 1, 0, 0, 1);
    add("acc3",         1, 0, 20,    3,   0,    5, 1, 0, 0, 1);
    add("acc4",         1, 0, 20,    1,   0,    6, 1, 0, 0, 1);
    add("acc59",        1, 0, 20,   55,   0,   19, 1, 0, 0, 1);
    add("acc60",        1, 0, 20,    1,   0,   20, 1, 1, 0, 2);
    add("run_hold",     1, 0, 20,   10,   0,   20, 1, 1, 0, 2);
    add("stop",         0, 0, 20,    0,   1,   20, 1, 0, 0, 3);
    add("dec7",         0, 0, 20,    7,   0,   20, 1, 0, 0, 3);
    add("dec8",         0, 0, 20,    1,   0,   19, 1, 0, 0, 3);
    add("dec120",       0, 0, 20,  112,   0,    5, 1, 0, 0, 3);
    add("dec127",       0, 0, 20,    7,   0,    5, 1, 0, 0, 3);
    add("dec128",       0, 0, 20,    1,   0,    0, 0, 0, 0, 0);
    add("low_tgt",      1, 0, 3,     5,   2,    0, 0, 0, 0, 0);
    add("tgt_fstart",   1, 0, 5,     0,   1,    5, 1, 0, 0, 1);
    add("run_fstart",   1, 0, 5,     0,   1,    5, 1, 1, 0, 2);
    add("rev_accel",    1, 0, 30,    0,   1,    5, 1, 0, 0, 1);
    add("rev_at10",     1, 0, 30,   20,   0,   10, 1, 0, 0, 1);
    add("rev_dec",      1, 0, 7,     0,   1,   10, 1, 0, 0, 3);
    add("rev_dec23",    1, 0, 7,    23,   0,    8, 1, 0, 0, 3);
    add("rev_run",      1, 0, 7,     1,   0,    7, 1, 1, 0, 2);
    add("estop",        1, 1, 7,     0,   1,    0, 0, 0, 1, 4);
    add("fault_hold",   1, 0, 7,     3,   2,    0, 0, 0, 1, 4);
    add("fault_clr",    0, 0, 7,     0,   1,    0, 0, 0, 0, 0);
    add("clamp_start",  1, 0, 1023,  0,   1,    5, 1, 0, 0, 1);
    add("clamp_999",    1, 0, 1023, 3979, 0,  999, 1, 0, 0, 1);
    add("clamp_1000",   1, 0, 1023,  1,   0, 1000, 1, 1, 0, 2);
    add("clamp_hold",   1, 0, 1023,  8,   0, 1000, 1, 1, 0, 2);
    add("clamp_estop",  1, 1, 1023,  0,   1,    0, 0, 0, 1, 4);
    add("clamp_clr",    0, 0, 1023,  0,   1,    0, 0, 0, 0, 0);
    add("coin_start",   1, 0, 30,    0,   1,    5, 1, 0, 0, 1);
    add("coin_cnt3",    1, 0, 30,    3,   0,    5, 1, 0, 0, 1);
    add("coin_switch",  0, 0, 30,    1,   0,    5, 1, 0, 0, 3);
    add("coin_dec7",    0, 0, 30,    7,   0,    5, 1, 0, 0, 3);
    add("coin_idle",    0, 0, 30,    1,   0,    0, 0, 0, 0, 0);

    repeat (2) @(posedge clk_sys);
    #1;
    push_exp("reset_hold", 0, 0, 0, 0, 0);
    check_pop();
    rst = 1'b0;
    tick(1'b0);
    push_exp("reset_idle", 0, 0, 0, 0, 0);
    check_pop();

    foreach (vecs[i]) begin
      run_req  = vecs[i].run;
      estop    = vecs[i].es;
      freq_tgt = vecs[i].tgt;
      exp_q.push_back(vecs[i].e);
      pulses(vecs[i].np);
      for (int k = 0; k < vecs[i].nt; k++) tick(1'b0);
      check_pop();
    end

    // Asynchronous reset in the middle of an acceleration ramp.
    run_req  = 1'b1;
    freq_tgt = FW'(30);
    push_exp("pre_rst", 12, 1, 0, 0, 1);
    tick(1'b0);
    pulses(28);
    check_pop();
    #2;
    rst = 1'b1;
    #1;
    push_exp("rst_async", 0, 0, 0, 0, 0);
    check_pop();
    run_req = 1'b0;
    tick(1'b0);
    rst = 1'b0;
    push_exp("rst_release", 0, 0, 0, 0, 0);
    tick(1'b0);
    check_pop();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vfd_ramp_ctrl.md
# vfd_ramp_ctrl

Soft-start / soft-stop sequencer between the HMI frequency setpoint and the VFD PWM core. It accepts a run request, a target frequency and an emergency stop. It drives the frequency word consumed by the VFD core, stepping it at a bounded acceleration and deceleration rate paced by the system millisecond strobe. It also gates the drive-enable and latches a fault on emergency stop until the operator clears the run request.

## Interface
Parameters:
- FW, 10: frequency word width.
- ACC_MS, 4: ms per +1 frequency step during acceleration; legal range 1..255.
- DEC_MS, 8: ms per -1 frequency step during deceleration; legal range 1..255.
- F_START, 5: first frequency applied on start and last frequency before stop; must be ≥1.
- F_MAX, 1000: clamp applied to the target.

Ports:
- clk_sys  in  1  system clock; all logic is in this one domain.
- rst  in  1  reset, asynchronous assert, active-high. Drives all registers to reset values.
- pluse_ms  in  1  one-clk_sys-cycle strobe, once per ms.
- run_req  in  1  level; 1 = motor should run.
- estop  in  1  level, already synchronous to clk_sys; 1 = emergency stop.
- freq_tgt  in  FW  requested frequency.
- freq_out  out  FW  frequency word to the VFD core; registered.
- drv_en  out  1  PWM output enable; registered.
- at_speed  out  1  1 while in RUN.
- fault  out  1  1 while in FAULT.
- state  out  3  state code: IDLE=0, ACCEL=1, RUN=2, DECEL=3, FAULT=4.

## Operation
Target:
- tgt_c = min(freq_tgt, F_MAX).
- Effective target tgt_e = tgt_c when run_req=1 and tgt_c ≥ F_START; otherwise 0, which means stop.

Step prescaler:
- An 8-bit ms counter increments on pluse_ms.
- In ACCEL, a step is due when pluse_ms=1 and the counter equals ACC_MS-1. In DECEL, the same applies with DEC_MS-1.
- When a step is due, the step is applied and the counter returns to 0.
- The counter clears on every state change.

Priority: estop first, then state transition, then step. If a transition and a step fall in the same cycle, the transition wins and no step is applied that cycle.

FSM:
- **IDLE**
  - Outputs: freq_out=0, drv_en=0.
  - tgt_e≠0 → ACCEL with freq_out←F_START and drv_en←1.
- **ACCEL**
  - freq_out==tgt_e → RUN.
  - tgt_e<freq_out, including tgt_e=0 → DECEL.
  - Otherwise freq_out+1 on each due step.
- **RUN**
  - Outputs: at_speed=1.
  - tgt_e>freq_out → ACCEL.
  - tgt_e<freq_out → DECEL.
  - Otherwise hold.
- **DECEL**
  - tgt_e≠0 and freq_out==tgt_e → RUN.
  - tgt_e>freq_out → ACCEL.
  - On a due step: if freq_out ≤ F_START and tgt_e=0 → IDLE, with freq_out←0 and drv_en←0; otherwise freq_out−1.
- **FAULT**
  - Entered from any state when estop=1.
  - Outputs: freq_out=0, drv_en=0, fault=1.
  - Exits to IDLE only when estop=0 and run_req=0, so there is no auto-restart while run_req is still held.

Arithmetic rules:
- freq_out never leaves [0, F_MAX].
- While drv_en=1, freq_out is never below F_START.
- Steps are exactly ±1 with no wrap.

Live target changes: freq_tgt may change at any time. The change is re-evaluated every cycle, so a reversal mid-ramp switches ACCEL↔DECEL with no freq_out jump.

## Timing
- Reset values: freq_out=0, drv_en=0, at_speed=0, fault=0, state=0 (IDLE), prescaler=0.
- After rst deasserts, the block is in IDLE on the first clock edge.
- All outputs are registered and change on the clk_sys edge after the qualifying input.
  - IDLE→ACCEL, freq_out=F_START and drv_en=1 appear one cycle after run_req/freq_tgt qualify.
  - estop=1 gives fault=1, drv_en=0 and freq_out=0 one cycle later, from any state.
- The first ACCEL step lands on the ACC_MS-th pluse_ms after entering ACCEL.
  - Ramp F_START→T takes (T−F_START)·ACC_MS pluse_ms.
  - Ramp T→stop takes (T−F_START+1)·DEC_MS pluse_ms.
- rst asserted mid-ramp forces reset values immediately (asynchronously). There is no resume.
- pluse_ms is ignored in IDLE, RUN and FAULT.

## Test plan
All scenarios use the default parameters.
- **Reset:** assert rst mid-ACCEL with freq_out=12 → all outputs 0 immediately; state=0 after release.
- **Start:** freq_tgt=20, run_req=1 → next cycle state=1, freq_out=5, drv_en=1; freq_out=6 at the 4th pluse_ms; freq_out=20 and state=2 (at_speed=1) after 60 pluse_ms.
- **Stop:** from RUN at 20, run_req=0 → state=3; freq_out=19 after 8 pluse_ms; freq_out=5 after 120; state=0, freq_out=0, drv_en=0 after 128.
- **Reversal:** in ACCEL at 10 set freq_tgt=7 → DECEL next cycle; freq_out reaches 7 after 24 pluse_ms, then state=2. Separately, freq_tgt=3 with run_req=1 from IDLE → stays IDLE.
- **Estop:** estop=1 in RUN at 20 → next cycle state=4, fault=1, freq_out=0, drv_en=0. Then estop=0 with run_req=1 → stays FAULT. Then run_req=0 → IDLE next cycle.
- **Clamp and coincidence:** freq_tgt=1023 → ramp stops at 1000. A pluse_ms that coincides with a target-induced ACCEL→DECEL switch → no step that cycle and the prescaler restarts at 0.
